// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIGITS seven-segment scanner with dead time, 16-level PWM, dp and leading-zero blanking.
// Latency: pins are registered and lag the internal slot/digit state by one cycle; frame_tick follows the snapshot by one cycle.
// Backpressure: none; free-running scan, inputs snapshotted once per frame (brightness/enable sampled live).
module seg7_scan_driver #(
    parameter int NDIGITS        = 4,
    parameter int SLOT_CYCLES    = 1024,
    parameter int DEAD_CYCLES    = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   lz_blank,
    input  logic                   enable,
    input  logic [3:0]             brightness,
    output logic [6:0]             seg,
    output logic                   dp_out,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic                   frame_tick
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CW-1:0]      CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]      CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NDIGITS - 1);
    localparam logic [6:0]         SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [NDIGITS-1:0] DIG_INV  = (DIG_ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   sh_value;
    logic [NDIGITS-1:0]     sh_dp;
    logic                   sh_lz;

    logic                   snap;
    logic                   lit;
    logic [NDIGITS-1:0]     supp;
    logic                   all_zero;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_supp;
    logic [NDIGITS-1:0]     cur_onehot;

    // Active-high glyph for one hex nibble, bit order g..a.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'b0111111;
            4'h1:    glyph = 7'b0000110;
            4'h2:    glyph = 7'b1011011;
            4'h3:    glyph = 7'b1001111;
            4'h4:    glyph = 7'b1100110;
            4'h5:    glyph = 7'b1101101;
            4'h6:    glyph = 7'b1111101;
            4'h7:    glyph = 7'b0000111;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1100111;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b1111100;
            4'hC:    glyph = 7'b0111001;
            4'hD:    glyph = 7'b1011110;
            4'hE:    glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    assign snap = (cnt == '0) && (idx == '0);
    assign lit  = enable && (cnt >= CNT_DEAD) && (cnt[3:0] <= brightness);

    // Leading-zero mask: a digit is blanked when it and every more significant shadow nibble are zero; digit 0 never is.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (sh_value[4*k +: 4] == 4'd0);
            supp[k]  = sh_lz & all_zero;
        end
    end

    // Select nibble, dp, blanking flag and one-hot enable for the digit currently being scanned.
    always_comb begin
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        cur_supp   = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib       = sh_value[4*i +: 4];
                cur_dp        = sh_dp[i];
                cur_supp      = supp[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // Slot counter and digit index; idx advances when the slot counter wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Frame snapshot so a displayed frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_lz    <= 1'b0;
        end else if (snap) begin
            sh_value <= value;
            sh_dp    <= dp;
            sh_lz    <= lz_blank;
        end
    end

    // Registered pins, with polarity applied last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= SEG_INV;
            dp_out     <= SEG_INV[0];
            digit_sel  <= DIG_INV;
            frame_tick <= 1'b0;
        end else begin
            seg        <= ((lit && !cur_supp) ? glyph(cur_nib) : 7'd0) ^ SEG_INV;
            dp_out     <= (lit & cur_dp) ^ SEG_INV[0];
            digit_sel  <= (lit ? cur_onehot : {NDIGITS{1'b0}}) ^ DIG_INV;
            frame_tick <= snap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SL = 32;
    localparam int DE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = 16'h0;
    logic [3:0]    dp = 4'h0;
    logic          lz_blank = 1'b0;
    logic          enable = 1'b0;
    logic [3:0]    brightness = 4'h0;

    logic [6:0]    hi_seg, lo_seg;
    logic          hi_dp, lo_dp;
    logic [3:0]    hi_dig, lo_dig;
    logic          hi_ft, lo_ft;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NDIGITS(ND), .SLOT_CYCLES(SL), .DEAD_CYCLES(DE),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .lz_blank(lz_blank),
        .enable(enable), .brightness(brightness), .seg(hi_seg), .dp_out(hi_dp),
        .digit_sel(hi_dig), .frame_tick(hi_ft));

    seg7_scan_driver #(.NDIGITS(ND), .SLOT_CYCLES(SL), .DEAD_CYCLES(DE),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .lz_blank(lz_blank),
        .enable(enable), .brightness(brightness), .seg(lo_seg), .dp_out(lo_dp),
        .digit_sel(lo_dig), .frame_tick(lo_ft));

    // Glyph table, active high, g..a.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Behavioural model: t counts cycles since reset release, slot/digit derived arithmetically.
    int          t = 0;
    bit          mvalid = 0;
    logic [15:0] shv = 0;
    logic [3:0]  shdp = 0;
    logic        shlz = 0;
    logic [6:0]  e_seg = 0;
    logic        e_dp = 0;
    logic [3:0]  e_dig = 0;
    logic        e_ft = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int c, d, nib;
        bit supp, lit;
        if (mvalid) begin
            chk("hi_seg", {25'd0, hi_seg}, {25'd0, e_seg});
            chk("hi_dp", {31'd0, hi_dp}, {31'd0, e_dp});
            chk("hi_dig", {28'd0, hi_dig}, {28'd0, e_dig});
            chk("hi_ft", {31'd0, hi_ft}, {31'd0, e_ft});
            chk("lo_seg", {25'd0, lo_seg}, {25'd0, ~e_seg});
            chk("lo_dp", {31'd0, lo_dp}, {31'd0, ~e_dp});
            chk("lo_dig", {28'd0, lo_dig}, {28'd0, ~e_dig});
            chk("lo_ft", {31'd0, lo_ft}, {31'd0, e_ft});
        end
        if (!rst_n) begin
            t = 0; shv = 0; shdp = 0; shlz = 0;
            e_seg = 0; e_dp = 0; e_dig = 0; e_ft = 0;
        end else begin
            c    = t % SL;
            d    = (t / SL) % ND;
            nib  = int'((shv >> (4 * d)) & 16'hF);
            supp = shlz && (d != 0) && ((shv >> (4 * d)) == 16'h0);
            lit  = enable && (c >= DE) && ((c % 16) <= int'(brightness));
            e_dig = lit ? 4'(1 << d) : 4'd0;
            e_seg = (lit && !supp) ? glyph_tab[nib] : 7'd0;
            e_dp  = lit ? shdp[d] : 1'b0;
            e_ft  = ((t % (ND * SL)) == 0);
            if (e_ft) begin
                shv = value; shdp = dp; shlz = lz_blank;
            end
            t++;
        end
        mvalid = 1;
    end

    // Stimulus helpers: inputs change only just after a rising edge; pins are read on falling edges.
    int jnow = 0;

    task automatic at_pos();
        @(posedge clk); #1;
    endtask

    task automatic wait_ft();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hi_ft !== 1'b1 && n < 400);
        total++;
        if (hi_ft !== 1'b1) begin
            bad++;
            $display("FAIL wait_ft: frame_tick absent after %0d cycles, expected within 400", n);
        end
        jnow = 0;
    endtask

    task automatic go_j(input int n);
        while (jnow < n) begin
            @(negedge clk);
            jnow++;
        end
    endtask

    initial begin
        // Reset for three cycles, value preloaded so the first snapshot picks it up.
        value = 16'h1A3F; brightness = 4'hF; enable = 1'b1; dp = 4'h0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi_dig", {28'd0, hi_dig}, 32'h0);
        chk("rst_hi_seg", {25'd0, hi_seg}, 32'h0);
        chk("rst_hi_ft", {31'd0, hi_ft}, 32'h0);
        chk("rst_lo_seg", {25'd0, lo_seg}, 32'h7F);
        chk("rst_lo_dig", {28'd0, lo_dig}, 32'hF);
        at_pos(); rst_n = 1'b1;
        @(negedge clk);
        chk("ft_cycle1", {31'd0, hi_ft}, 32'h0);
        @(negedge clk);
        chk("ft_cycle2", {31'd0, hi_ft}, 32'h1);
        jnow = 0;

        // Scan order and glyphs for 16'h1A3F.
        go_j(3);   chk("dead_dig", {28'd0, hi_dig}, 32'h0);
        go_j(5);   chk("d0_dig", {28'd0, hi_dig}, 32'h1);  chk("d0_seg", {25'd0, hi_seg}, 32'h71);
        go_j(37);  chk("d1_dig", {28'd0, hi_dig}, 32'h2);  chk("d1_seg", {25'd0, hi_seg}, 32'h4F);
        go_j(66);  chk("d2_dead", {28'd0, hi_dig}, 32'h0);
        go_j(69);  chk("d2_dig", {28'd0, hi_dig}, 32'h4);  chk("d2_seg", {25'd0, hi_seg}, 32'h77);
        go_j(101); chk("d3_dig", {28'd0, hi_dig}, 32'h8);  chk("d3_seg", {25'd0, hi_seg}, 32'h06);
        chk("lo_d3_seg", {25'd0, lo_seg}, 32'h79);
        go_j(127); chk("ft_gap", {31'd0, hi_ft}, 32'h0);
        go_j(128); chk("ft_period", {31'd0, hi_ft}, 32'h1);

        // Tear-free snapshot: change during digit 2 of the frame.
        at_pos(); value = 16'h1111;
        wait_ft(); wait_ft();
        go_j(74); at_pos(); value = 16'h2222;
        go_j(101); chk("tear_d3_seg", {25'd0, hi_seg}, 32'h06);
        wait_ft();
        go_j(5);   chk("new_d0_seg", {25'd0, hi_seg}, 32'h5B);

        // Leading-zero suppression with dp on a blanked digit.
        at_pos(); value = 16'h0050; lz_blank = 1'b1; dp = 4'b1000;
        wait_ft(); wait_ft();
        go_j(5);   chk("lz_d0_seg", {25'd0, hi_seg}, 32'h3F);
        go_j(37);  chk("lz_d1_seg", {25'd0, hi_seg}, 32'h6D);
        go_j(69);  chk("lz_d2_seg", {25'd0, hi_seg}, 32'h0);  chk("lz_d2_dig", {28'd0, hi_dig}, 32'h4);
        go_j(101); chk("lz_d3_seg", {25'd0, hi_seg}, 32'h0);  chk("lz_d3_dp", {31'd0, hi_dp}, 32'h1);

        // Brightness 3: only cnt 16..19 lit in each slot.
        at_pos(); brightness = 4'd3; value = 16'h0000;
        wait_ft(); wait_ft();
        go_j(4);   chk("br_c4", {28'd0, hi_dig}, 32'h0);
        go_j(17);  chk("br_c17", {28'd0, hi_dig}, 32'h1);  chk("zero_d0", {25'd0, hi_seg}, 32'h3F);
        go_j(20);  chk("br_c20", {28'd0, hi_dig}, 32'h0);
        go_j(49);  chk("zero_d1", {25'd0, hi_seg}, 32'h0);  chk("zero_d1_dig", {28'd0, hi_dig}, 32'h2);

        // Enable low: display dark while frame_tick keeps running.
        at_pos(); enable = 1'b0; brightness = 4'hF;
        wait_ft();
        go_j(40);  chk("en0_dig", {28'd0, hi_dig}, 32'h0);
        wait_ft();

        // Randomized phase against the model, including a mid-slot reset.
        for (int i = 0; i < 4000; i++) begin
            at_pos();
            if ($urandom_range(0, 15) == 0) value = 16'($urandom);
            if ($urandom_range(0, 31) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 63) == 0) lz_blank = 1'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 99) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0 && i[0]) value = {4'h0, 4'h0, 4'($urandom), 4'($urandom)};
            if (i == 2000) rst_n = 1'b0;
            if (i == 2002) rst_n = 1'b1;
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
